pe_result_collector: RTL and testbench

Downstream stage of PE_single_module. Captures the serial result stream (acc_out qualified by en_result) of one single-mode run into a 2x2 output register file (c_1_1..c_2_2, row-major). Presents the full matrix to the consumer with a valid/ack handshake. Flags protocol faults: short run, overrun, stalled PE.

---
 rtl/pe_result_collector_pkg.sv | 27 ++
 rtl/pe_result_collector_timeout.sv | 34 +++
 rtl/pe_result_collector.sv | 169 ++++++++++++++++
 tb/tb_pe_result_collector.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pe_result_collector_pkg.sv
// Shared types and constants for the PE result collector family.
// State and fault encodings are shared with the future PE-array collector.
package pe_result_collector_pkg;

    localparam int NUM_OUT    = 4;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_DONE    = 2'b10,
        ST_ERR     = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_SHORT   = 2'b01,
        ERR_OVERRUN = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    function automatic logic is_full(input logic [CNT_W-1:0] cnt);
        return (cnt == 3'(NUM_OUT));
    endfunction

endpackage

// File: rtl/pe_result_collector_timeout.sv
// pe_result_timeout: saturating idle-cycle counter with clear and expire.
// expire fires in the cycle whose increment would bring the count to TIMEOUT_CYC-1.
module pe_result_timeout #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(TIMEOUT_CYC - 2);

    logic [CW-1:0] cnt_r;

    // Idle-cycle counter: cleared on activity, saturates at its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (run && (cnt_r != CNT_LAST)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = run && !clear && (cnt_r == CNT_PRE);

endmodule

// File: rtl/pe_result_collector.sv
// Captures one 2x2 single-mode PE result run into a register file and hands it
// to the consumer with a valid/ack handshake, flagging short, overrun and stall faults.
module pe_result_collector
    import pe_result_collector_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_result,
    input  logic [DATA_W-1:0] acc_out,
    input  logic              pe_done,
    input  logic              result_ack,
    output logic [DATA_W-1:0] c_1_1,
    output logic [DATA_W-1:0] c_1_2,
    output logic [DATA_W-1:0] c_2_1,
    output logic [DATA_W-1:0] c_2_2,
    output logic [2:0]        result_cnt,
    output logic              result_valid,
    output logic              err,
    output logic [1:0]        err_code
);

    state_t            state_r, state_s;
    logic [DATA_W-1:0] data_r [NUM_OUT];
    logic [DATA_W-1:0] data_s [NUM_OUT];
    logic [CNT_W-1:0]  cnt_r, cnt_s, post_cnt_s;
    logic              valid_r, valid_s;
    logic              err_r, err_s;
    err_code_t         code_r, code_s;
    logic              timer_run_s, timer_clear_s, expire_s;

    assign timer_run_s   = (state_r == ST_COLLECT) && !en_result;
    assign timer_clear_s = (state_r != ST_COLLECT) || en_result;

    pe_result_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .run    (timer_run_s),
        .clear  (timer_clear_s),
        .expire (expire_s)
    );

    // Next-state and next-output computation for the capture FSM.
    always_comb begin
        state_s    = state_r;
        data_s     = data_r;
        cnt_s      = cnt_r;
        valid_s    = valid_r;
        err_s      = err_r;
        code_s     = code_r;
        post_cnt_s = cnt_r + {2'b00, en_result};
        case (state_r)
            ST_IDLE: begin
                if (en_result) begin
                    data_s[0] = acc_out;
                    cnt_s     = 3'd1;
                    if (pe_done) begin
                        state_s = ST_ERR;
                        err_s   = 1'b1;
                        code_s  = ERR_SHORT;
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end else if (pe_done) begin
                    state_s = ST_ERR;
                    err_s   = 1'b1;
                    code_s  = ERR_SHORT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (en_result && is_full(cnt_r)) begin
                    state_s = ST_ERR;
                    err_s   = 1'b1;
                    code_s  = ERR_OVERRUN;
                end else begin
                    if (en_result) begin
                        data_s[cnt_r[1:0]] = acc_out;
                        cnt_s              = post_cnt_s;
                    end else begin
                        cnt_s = cnt_r;
                    end
                    // pe_done outranks a simultaneous timeout expiry.
                    if (pe_done) begin
                        if (is_full(post_cnt_s)) begin
                            state_s = ST_DONE;
                            valid_s = 1'b1;
                        end else begin
                            state_s = ST_ERR;
                            err_s   = 1'b1;
                            code_s  = ERR_SHORT;
                        end
                    end else if (expire_s) begin
                        state_s = ST_ERR;
                        err_s   = 1'b1;
                        code_s  = ERR_TIMEOUT;
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end
            end
            ST_DONE: begin
                if (en_result) begin
                    state_s = ST_ERR;
                    valid_s = 1'b0;
                    err_s   = 1'b1;
                    code_s  = ERR_OVERRUN;
                end else if (result_ack) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    cnt_s   = 3'd0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_ERR: begin
                if (result_ack) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b0;
                    code_s  = ERR_NONE;
                    cnt_s   = 3'd0;
                end else begin
                    state_s = ST_ERR;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                err_s   = 1'b0;
                code_s  = ERR_NONE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            for (int i = 0; i < NUM_OUT; i++) begin
                data_r[i] <= {DATA_W{1'b0}};
            end
            cnt_r   <= 3'd0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            code_r  <= ERR_NONE;
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            cnt_r   <= cnt_s;
            valid_r <= valid_s;
            err_r   <= err_s;
            code_r  <= code_s;
        end
    end

    assign c_1_1        = data_r[0];
    assign c_1_2        = data_r[1];
    assign c_2_1        = data_r[2];
    assign c_2_2        = data_r[3];
    assign result_cnt   = cnt_r;
    assign result_valid = valid_r;
    assign err          = err_r;
    assign err_code     = code_r;

endmodule

// File: tb/tb_pe_result_collector.sv
// Self-checking bench for pe_result_collector: vector table, directed corner
// sequences, then random traffic checked against a run-level reference model.
module tb_pe_result_collector;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       reset, en_result, pe_done, result_ack;
    logic [7:0] acc_out;
    logic [7:0] c_1_1, c_1_2, c_2_1, c_2_2;
    logic [2:0] result_cnt;
    logic       result_valid, err;
    logic [1:0] err_code;

    int tests = 0;
    int fails = 0;

    pe_result_collector #(.DATA_W(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .en_result(en_result), .acc_out(acc_out),
        .pe_done(pe_done), .result_ack(result_ack),
        .c_1_1(c_1_1), .c_1_2(c_1_2), .c_2_1(c_2_1), .c_2_2(c_2_2),
        .result_cnt(result_cnt), .result_valid(result_valid),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Reference model: captured bytes, count, run flags, idle-gap length.
    logic [7:0] m_c [4];
    int         m_n, m_gap, m_code;
    bit         m_started, m_valid, m_err;

    task automatic m_fault(input int code);
        m_err = 1'b1; m_code = code; m_valid = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit en, input logic [7:0] d,
                              input bit done, input bit ack);
        if (r) begin
            for (int i = 0; i < 4; i++) m_c[i] = 8'd0;
            m_n = 0; m_gap = 0; m_code = 0;
            m_started = 1'b0; m_valid = 1'b0; m_err = 1'b0;
        end else if (m_err) begin
            if (ack) begin m_err = 1'b0; m_code = 0; m_n = 0; m_started = 1'b0; end
        end else if (m_valid) begin
            if (en) m_fault(2);
            else if (ack) begin m_valid = 1'b0; m_n = 0; m_started = 1'b0; end
        end else if (en && m_n == 4) begin
            m_fault(2);
        end else begin
            if (en) begin m_c[m_n] = d; m_n++; m_gap = 0; m_started = 1'b1; end
            else if (m_started) m_gap++;
            if (done) begin
                if (m_n == 4) m_valid = 1'b1; else m_fault(1);
            end else if (m_started && !en && m_gap == TO - 1) begin
                m_fault(3);
            end
        end
    endtask

    task automatic step(input bit r, input bit en, input logic [7:0] d,
                        input bit done, input bit ack);
        reset = r; en_result = en; acc_out = d; pe_done = done; result_ack = ack;
        model_step(r, en, d, done, ack);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e11, input int e12, input int e21,
                           input int e22, input int ecnt, input int evalid,
                           input int eerr, input int ecode);
        chk({tag, " c_1_1"}, 32'(c_1_1), 32'(e11));
        chk({tag, " c_1_2"}, 32'(c_1_2), 32'(e12));
        chk({tag, " c_2_1"}, 32'(c_2_1), 32'(e21));
        chk({tag, " c_2_2"}, 32'(c_2_2), 32'(e22));
        chk({tag, " result_cnt"}, 32'(result_cnt), 32'(ecnt));
        chk({tag, " result_valid"}, 32'(result_valid), 32'(evalid));
        chk({tag, " err"}, 32'(err), 32'(eerr));
        chk({tag, " err_code"}, 32'(err_code), 32'(ecode));
    endtask

    typedef struct {
        bit rst; bit en; logic [7:0] d; bit done; bit ack;
        int e11; int e12; int e21; int e22; int ecnt; int evalid; int eerr; int ecode;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit en, input int d, input bit done, input bit ack,
                       input int e11, input int e12, input int e21, input int e22,
                       input int ecnt, input int evalid, input int eerr, input int ecode);
        vec_t v;
        v.rst = rst; v.en = en; v.d = 8'(d); v.done = done; v.ack = ack;
        v.e11 = e11; v.e12 = e12; v.e21 = e21; v.e22 = e22;
        v.ecnt = ecnt; v.evalid = evalid; v.eerr = eerr; v.ecode = ecode;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; en_result = 1'b0; acc_out = 8'd0; pe_done = 1'b0; result_ack = 1'b0;

        //  rst en  d   dn ack   c11 c12 c21 c22 cnt vld err code
        add(1, 0,  0,  0, 0,    0,  0,  0,  0,  0,  0,  0,  0);  // reset state
        add(0, 1, 10,  0, 0,   10,  0,  0,  0,  1,  0,  0,  0);  // normal run
        add(0, 1, 20,  0, 0,   10, 20,  0,  0,  2,  0,  0,  0);
        add(0, 1, 30,  0, 0,   10, 20, 30,  0,  3,  0,  0,  0);
        add(0, 1, 40,  1, 0,   10, 20, 30, 40,  4,  1,  0,  0);
        add(0, 0,  0,  0, 0,   10, 20, 30, 40,  4,  1,  0,  0);
        add(0, 0,  0,  0, 1,   10, 20, 30, 40,  0,  0,  0,  0);
        add(0, 0,  0,  0, 0,   10, 20, 30, 40,  0,  0,  0,  0);
        add(0, 1,  7,  0, 0,    7, 20, 30, 40,  1,  0,  0,  0);  // short run
        add(0, 1,  8,  0, 0,    7,  8, 30, 40,  2,  0,  0,  0);
        add(0, 0,  0,  1, 0,    7,  8, 30, 40,  2,  0,  1,  1);
        add(0, 1, 99,  0, 0,    7,  8, 30, 40,  2,  0,  1,  1);
        add(0, 0,  0,  0, 1,    7,  8, 30, 40,  0,  0,  0,  0);
        add(0, 1,  1,  0, 0,    1,  8, 30, 40,  1,  0,  0,  0);  // overrun
        add(0, 1,  2,  0, 0,    1,  2, 30, 40,  2,  0,  0,  0);
        add(0, 1,  3,  0, 0,    1,  2,  3, 40,  3,  0,  0,  0);
        add(0, 1,  4,  0, 0,    1,  2,  3,  4,  4,  0,  0,  0);
        add(0, 1,  5,  0, 0,    1,  2,  3,  4,  4,  0,  1,  2);
        add(0, 0,  0,  0, 1,    1,  2,  3,  4,  0,  0,  0,  0);
        add(0, 1, 11,  0, 0,   11,  2,  3,  4,  1,  0,  0,  0);  // DONE corner cases
        add(0, 1, 12,  0, 0,   11, 12,  3,  4,  2,  0,  0,  0);
        add(0, 1, 13,  0, 0,   11, 12, 13,  4,  3,  0,  0,  0);
        add(0, 1, 14,  1, 0,   11, 12, 13, 14,  4,  1,  0,  0);
        add(0, 0,  0,  1, 0,   11, 12, 13, 14,  4,  1,  0,  0);
        add(0, 1, 77,  0, 1,   11, 12, 13, 14,  4,  0,  1,  2);
        add(0, 0,  0,  0, 1,   11, 12, 13, 14,  0,  0,  0,  0);
        add(0, 0,  0,  1, 0,   11, 12, 13, 14,  0,  0,  1,  1);  // pe_done in IDLE
        add(0, 0,  0,  0, 1,   11, 12, 13, 14,  0,  0,  0,  0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].done, vecs[i].ack);
            chk_all($sformatf("vec%0d", i), vecs[i].e11, vecs[i].e12, vecs[i].e21,
                    vecs[i].e22, vecs[i].ecnt, vecs[i].evalid, vecs[i].eerr, vecs[i].ecode);
        end

        // Gapped strobes with pe_done two cycles after the last one.
        begin
            int vals [4] = '{233, 5, 9, 13};
            for (int k = 0; k < 4; k++) begin
                step(0, 1, 8'(vals[k]), 0, 0);
                for (int g = 0; g < ((k == 3) ? 2 : 3); g++) step(0, 0, 8'd0, 0, 0);
            end
            chk_all("gap pre-done", 233, 5, 9, 13, 4, 0, 0, 0);
            step(0, 0, 8'd0, 1, 0);
            chk_all("gap done", 233, 5, 9, 13, 4, 1, 0, 0);
            step(0, 0, 8'd0, 0, 1);
        end

        // Timeout: err must appear exactly TO cycles after the single strobe.
        step(0, 1, 8'd55, 0, 0);
        for (int k = 0; k < TO - 2; k++) step(0, 0, 8'd0, 0, 0);
        chk("timeout early err", 32'(err), 32'd0);
        step(0, 0, 8'd0, 0, 0);
        chk("timeout err", 32'(err), 32'd1);
        chk("timeout err_code", 32'(err_code), 32'd3);
        for (int k = 0; k < 6; k++) step(0, 0, 8'd0, 0, 0);
        chk("timeout hold err_code", 32'(err_code), 32'd3);
        step(0, 0, 8'd0, 0, 1);
        chk("timeout ack err", 32'(err), 32'd0);

        // Reset mid-run, then a clean run.
        step(0, 1, 8'd21, 0, 0);
        step(0, 1, 8'd22, 0, 0);
        step(0, 1, 8'd23, 0, 0);
        step(1, 0, 8'd0, 0, 0);
        chk_all("mid reset", 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 8'd50, 0, 0);
        step(0, 1, 8'd60, 0, 0);
        step(0, 1, 8'd70, 0, 0);
        step(0, 1, 8'd80, 1, 0);
        chk_all("post reset run", 50, 60, 70, 80, 4, 1, 0, 0);

        // Random traffic against the model, with quiet windows to provoke stalls.
        step(1, 0, 8'd0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit q;
            q = ((i % 400) >= 320);
            step(($urandom_range(0, 299) == 0),
                 !q && ($urandom_range(0, 99) < 40),
                 8'($urandom),
                 !q && ($urandom_range(0, 99) < 8),
                 !q && ($urandom_range(0, 99) < 15));
            chk_all($sformatf("rnd%0d", i), m_c[0], m_c[1], m_c[2], m_c[3],
                    m_n, m_valid, m_err, m_code);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
